// File: rtl/rf_wb_ctrl.sv
// Register-file write-side controller: merges ALU and long-op results onto one
// write port, tracks long-op destinations in a busy scoreboard, and stalls decode.
module rf_wb_ctrl #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lng_issue,
  input  logic [4:0]  lng_issue_rd,
  input  logic        lng_valid,
  input  logic [4:0]  lng_rd,
  input  logic [31:0] lng_data,
  output logic        lng_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic [4:0]  write_reg,
  output logic        write_en,
  output logic [31:0] write_data
);

  localparam int AW = $clog2(LQ_DEPTH);

  logic [4:0]    q_rd_mem   [LQ_DEPTH];
  logic [31:0]   q_data_mem [LQ_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ready_q;
  logic [31:0]   busy_q, busy_d;
  logic          from_lng_q;
  logic [4:0]    write_reg_q;
  logic          write_en_q;
  logic [31:0]   write_data_q;

  logic        full, empty, lng_acc;
  logic        sel_valid, sel_lng, push, pop, bypass;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign full      = (cnt_q == (AW+1)'(LQ_DEPTH));
  assign empty     = (cnt_q == '0);
  // Readiness looks only at the current fill level; a same-cycle pop does not count.
  assign lng_ready = ready_q & ~full;
  assign lng_acc   = lng_valid & lng_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_lng   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_lng   = 1'b1;
      sel_rd    = q_rd_mem[rd_ptr_q];
      sel_data  = q_data_mem[rd_ptr_q];
      pop       = 1'b1;
    end else if (lng_acc) begin
      sel_valid = 1'b1;
      sel_lng   = 1'b1;
      sel_rd    = lng_rd;
      sel_data  = lng_data;
      bypass    = 1'b1;
    end
    push = lng_acc & ~bypass;
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear on the edge where the register file captures a long write, then set new issues.
  always_comb begin
    busy_d = busy_q;
    if (write_en_q && from_lng_q) busy_d[write_reg_q] = 1'b0;
    if (lng_issue && lng_issue_rd != 5'd0) busy_d[lng_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign stall = busy_q[rs1] | busy_q[rs2] | (lng_issue & busy_q[lng_issue_rd]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= '0;
      from_lng_q   <= 1'b0;
      write_reg_q  <= '0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
    end else begin
      ready_q <= 1'b1;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      write_en_q <= sel_valid && (sel_rd != 5'd0);
      from_lng_q <= sel_valid && sel_lng;
      if (sel_valid) begin
        write_reg_q  <= sel_rd;
        write_data_q <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_rd_mem[wr_ptr_q]   <= lng_rd;
      q_data_mem[wr_ptr_q] <= lng_data;
    end
  end

  assign write_reg  = write_reg_q;
  assign write_en   = write_en_q;
  assign write_data = write_data_q;

  // ALU writes never target a register reserved by an outstanding long op.
  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(alu_valid && alu_rd != 5'd0 && busy_q[alu_rd]));

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: reset, ALU path, RAW/WAW stall, collision,
// backpressure drain and reset with a full queue.
module tb_rf_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lng_issue;
  logic [4:0]  lng_issue_rd;
  logic        lng_valid;
  logic [4:0]  lng_rd;
  logic [31:0] lng_data;
  logic        lng_ready;
  logic [4:0]  rs1, rs2;
  logic        stall;
  logic [4:0]  write_reg;
  logic        write_en;
  logic [31:0] write_data;

  int n_vec;
  int n_err;

  rf_wb_ctrl #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lng_issue(lng_issue), .lng_issue_rd(lng_issue_rd),
    .lng_valid(lng_valid), .lng_rd(lng_rd), .lng_data(lng_data),
    .lng_ready(lng_ready), .rs1(rs1), .rs2(rs2), .stall(stall),
    .write_reg(write_reg), .write_en(write_en), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lng_issue = 1'b0; lng_issue_rd = '0;
    lng_valid = 1'b0; lng_rd = '0; lng_data = '0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_vec({tag, "_en"}, 32'(write_en), 32'd1);
    check_vec({tag, "_reg"}, 32'(write_reg), 32'(rd));
    check_vec({tag, "_data"}, write_data, data);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    idle();
    rs1 = '0; rs2 = '0;

    // Reset held for 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      cyc();
      alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom_range(0, 31));
      alu_data = $urandom; lng_issue = 1'($urandom_range(0, 1));
      lng_issue_rd = 5'($urandom_range(0, 31)); lng_valid = 1'($urandom_range(0, 1));
      lng_rd = 5'($urandom_range(0, 31)); lng_data = $urandom;
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      #1;
      check_vec("rst_write_en", 32'(write_en), 32'd0);
      check_vec("rst_stall", 32'(stall), 32'd0);
      check_vec("rst_lng_ready", 32'(lng_ready), 32'd0);
    end
    idle();
    rs1 = '0; rs2 = '0;
    rst = 1'b1;
    cyc();
    check_vec("post_rst_lng_ready", 32'(lng_ready), 32'd1);
    check_vec("post_rst_write_en", 32'(write_en), 32'd0);

    // ALU path
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cyc();
    idle();
    check_write("alu_rd5", 5'd5, 32'hDEADBEEF);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    cyc();
    idle();
    check_vec("alu_rd0_en", 32'(write_en), 32'd0);
    cyc();
    check_vec("idle_en", 32'(write_en), 32'd0);

    // x0 is never marked busy
    lng_issue = 1'b1; lng_issue_rd = 5'd0;
    cyc();
    idle();
    #1;
    check_vec("x0_not_busy", 32'(stall), 32'd0);

    // RAW stall on rd=7
    lng_issue = 1'b1; lng_issue_rd = 5'd7;
    #1;
    check_vec("raw_issue_nostall", 32'(stall), 32'd0);
    cyc();
    idle();
    rs1 = 5'd7;
    #1;
    check_vec("raw_stall_0", 32'(stall), 32'd1);
    for (int i = 1; i < 3; i++) begin
      cyc();
      check_vec("raw_stall_hold", 32'(stall), 32'd1);
    end
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    check_vec("raw_stall_rs2", 32'(stall), 32'd1);
    rs2 = 5'd0;
    lng_issue = 1'b1; lng_issue_rd = 5'd7;
    #1;
    check_vec("waw_stall", 32'(stall), 32'd1);
    lng_issue = 1'b0; lng_issue_rd = '0;
    rs1 = 5'd7;
    lng_valid = 1'b1; lng_rd = 5'd7; lng_data = 32'h12345678;
    #1;
    check_vec("raw_lng_ready", 32'(lng_ready), 32'd1);
    cyc();
    idle();
    check_write("raw_write", 5'd7, 32'h12345678);
    check_vec("raw_stall_at_write", 32'(stall), 32'd1);
    cyc();
    check_vec("raw_stall_clear", 32'(stall), 32'd0);
    check_vec("raw_after_en", 32'(write_en), 32'd0);

    // Collision: ALU rd=3 and long rd=4 together
    rs1 = 5'd0;
    lng_issue = 1'b1; lng_issue_rd = 5'd4;
    cyc();
    idle();
    rs2 = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003;
    lng_valid = 1'b1; lng_rd = 5'd4; lng_data = 32'hBBBB_0004;
    #1;
    check_vec("col_stall_pre", 32'(stall), 32'd1);
    cyc();
    idle();
    check_write("col_first", 5'd3, 32'hAAAA_0003);
    check_vec("col_busy4_a", 32'(stall), 32'd1);
    cyc();
    check_write("col_second", 5'd4, 32'hBBBB_0004);
    check_vec("col_busy4_b", 32'(stall), 32'd1);
    cyc();
    check_vec("col_busy4_clear", 32'(stall), 32'd0);
    check_vec("col_idle_en", 32'(write_en), 32'd0);
    rs2 = 5'd0;

    // Backpressure: continuous ALU stream, three long results offered
    for (int i = 0; i < 3; i++) begin
      lng_issue = 1'b1; lng_issue_rd = 5'(10 + i);
      cyc();
    end
    idle();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
    lng_valid = 1'b1; lng_rd = 5'd10; lng_data = 32'hC0;
    #1;
    check_vec("bp_ready_0", 32'(lng_ready), 32'd1);
    cyc();
    check_write("bp_alu_0", 5'd1, 32'h100);
    alu_data = 32'h101; lng_rd = 5'd11; lng_data = 32'hC1;
    #1;
    check_vec("bp_ready_1", 32'(lng_ready), 32'd1);
    cyc();
    check_write("bp_alu_1", 5'd1, 32'h101);
    alu_data = 32'h102; lng_rd = 5'd12; lng_data = 32'hC2;
    #1;
    check_vec("bp_ready_full", 32'(lng_ready), 32'd0);
    cyc();
    check_write("bp_alu_2", 5'd1, 32'h102);
    alu_valid = 1'b0;
    #1;
    check_vec("bp_ready_still_full", 32'(lng_ready), 32'd0);
    cyc();
    check_write("bp_drain_10", 5'd10, 32'hC0);
    check_vec("bp_ready_space", 32'(lng_ready), 32'd1);
    cyc();
    lng_valid = 1'b0;
    check_write("bp_drain_11", 5'd11, 32'hC1);
    cyc();
    check_write("bp_drain_12", 5'd12, 32'hC2);
    cyc();
    check_vec("bp_drain_done", 32'(write_en), 32'd0);
    rs1 = 5'd10; rs2 = 5'd12;
    #1;
    check_vec("bp_busy_clear", 32'(stall), 32'd0);
    rs1 = '0; rs2 = '0;

    // Reset while the queue is full and scoreboard bits are set
    lng_issue = 1'b1; lng_issue_rd = 5'd20;
    cyc();
    lng_issue_rd = 5'd21;
    cyc();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h200;
    lng_valid = 1'b1; lng_rd = 5'd20; lng_data = 32'hD0;
    cyc();
    lng_rd = 5'd21; lng_data = 32'hD1;
    cyc();
    lng_valid = 1'b0;
    rs1 = 5'd20; rs2 = 5'd21;
    #1;
    check_vec("rq_full_ready", 32'(lng_ready), 32'd0);
    check_vec("rq_stall_set", 32'(stall), 32'd1);
    idle();
    rst = 1'b0;
    cyc();
    check_vec("rq_rst_en", 32'(write_en), 32'd0);
    check_vec("rq_rst_stall", 32'(stall), 32'd0);
    check_vec("rq_rst_ready", 32'(lng_ready), 32'd0);
    rst = 1'b1;
    cyc();
    check_vec("rq_rel_ready", 32'(lng_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_vec("rq_no_stale_en", 32'(write_en), 32'd0);
      check_vec("rq_no_stale_stall", 32'(stall), 32'd0);
      cyc();
    end
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
    cyc();
    idle();
    check_write("rq_alu_after", 5'd9, 32'h0909_0909);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
